// File: rtl/heap_array_unit.sv
// Array heap: up to NArrays dynamic arrays of NArea words each, with LIFO reuse of freed arrays.
// One request at a time through a three-state IDLE/EXEC/RESP handshake.
module heap_array_unit #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int NArrays            = 16,
    localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1,
    localparam int IW = (NArea > 1) ? $clog2(NArea) : 1,
    localparam int W  = MemoryElementWidth
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          reqValid,
    output logic          reqReady,
    input  logic [2:0]    reqOp,
    input  logic [AW-1:0] reqArray,
    input  logic [IW-1:0] reqIndex,
    input  logic [W-1:0]  reqData,
    output logic          rspValid,
    input  logic          rspReady,
    output logic [W-1:0]  rspData,
    output logic          rspError,
    output logic [AW:0]   allocCount
);

    localparam int SW    = $clog2(NArea + 1);
    localparam int Depth = NArrays * NArea;
    localparam int HW    = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [2:0] OP_ALLOC = 3'd0;
    localparam logic [2:0] OP_FREE  = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_WRITE = 3'd5;
    localparam logic [2:0] OP_SIZE  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [AW-1:0]      arr_q;
    logic [IW-1:0]      idx_q;
    logic [W-1:0]       data_q;
    logic [W-1:0]       heap [Depth];
    logic [SW-1:0]      size_q [NArrays];
    logic [NArrays-1:0] flag_q;
    logic [AW-1:0]      stk [NArrays];
    logic [AW:0]        top_q;
    logic [AW:0]        fresh_q;
    logic [AW:0]        alloc_q;
    logic [W-1:0]       rsp_data_q;
    logic               rsp_err_q;

    logic               arr_ok;
    logic               live;
    logic               from_stack;
    logic [AW-1:0]      alloc_id;
    logic [SW-1:0]      cur_size;
    logic [SW-1:0]      size_new;
    logic [HW-1:0]      base;
    logic [HW-1:0]      addr;
    logic               ex_err;
    logic [W-1:0]       ex_data;
    logic               heap_we;
    logic               size_we;

    // Decode of the latched request; only acted upon while in EXEC.
    always_comb begin
        arr_ok     = {1'b0, arr_q} < (AW+1)'(NArrays);
        live       = arr_ok && flag_q[arr_q];
        cur_size   = size_q[arr_q];
        base       = HW'(arr_q) * HW'(NArea);
        addr       = base + HW'(idx_q);
        from_stack = (top_q != '0);
        alloc_id   = from_stack ? stk[AW'(top_q - (AW+1)'(1))] : fresh_q[AW-1:0];
        ex_err     = 1'b0;
        ex_data    = '0;
        heap_we    = 1'b0;
        size_we    = 1'b0;
        size_new   = cur_size;
        case (op_q)
            OP_ALLOC: begin
                ex_err  = !from_stack && (fresh_q == (AW+1)'(NArrays));
                ex_data = W'(alloc_id);
            end
            OP_FREE: ex_err = !live;
            OP_PUSH: begin
                ex_err   = !live || (cur_size == SW'(NArea));
                addr     = base + HW'(cur_size);
                size_new = cur_size + SW'(1);
                size_we  = 1'b1;
                heap_we  = 1'b1;
                ex_data  = W'(size_new);
            end
            OP_POP: begin
                ex_err   = !live || (cur_size == '0);
                size_new = cur_size - SW'(1);
                size_we  = 1'b1;
                addr     = base + HW'(size_new);
                ex_data  = heap[addr];
            end
            OP_READ: begin
                ex_err  = !live || (SW'(idx_q) >= cur_size);
                ex_data = heap[addr];
            end
            OP_WRITE: begin
                ex_err  = !live || ({1'b0, idx_q} >= (IW+1)'(NArea));
                heap_we = 1'b1;
                if (SW'(idx_q) >= cur_size) begin
                    size_we  = 1'b1;
                    size_new = SW'(idx_q) + SW'(1);
                end
            end
            OP_SIZE: begin
                ex_err  = !live;
                ex_data = W'(cur_size);
            end
            default: ex_err = 1'b1;
        endcase
        if (ex_err) begin
            ex_data = '0;
            heap_we = 1'b0;
            size_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= '0;
            arr_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            flag_q     <= '0;
            top_q      <= '0;
            fresh_q    <= '0;
            alloc_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < NArrays; i++) size_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        op_q   <= reqOp;
                        arr_q  <= reqArray;
                        idx_q  <= reqIndex;
                        data_q <= reqData;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    state      <= RESP;
                    rsp_err_q  <= ex_err;
                    rsp_data_q <= ex_data;
                    if (!ex_err) begin
                        if (op_q == OP_ALLOC) begin
                            flag_q[alloc_id] <= 1'b1;
                            size_q[alloc_id] <= '0;
                            alloc_q          <= alloc_q + (AW+1)'(1);
                            if (from_stack) top_q <= top_q - (AW+1)'(1);
                            else            fresh_q <= fresh_q + (AW+1)'(1);
                        end else if (op_q == OP_FREE) begin
                            flag_q[arr_q] <= 1'b0;
                            top_q         <= top_q + (AW+1)'(1);
                            alloc_q       <= alloc_q - (AW+1)'(1);
                        end else if (size_we) begin
                            size_q[arr_q] <= size_new;
                        end
                    end
                end
                RESP: if (rspReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Heap words and free-list slots are never reset; the top pointer defines what is valid.
    always_ff @(posedge clock) begin
        if (reset && state == EXEC && !ex_err) begin
            if (heap_we) heap[addr] <= data_q;
            if (op_q == OP_FREE) stk[AW'(top_q)] <= arr_q;
        end
    end

    assign reqReady   = (state == IDLE);
    assign rspValid   = (state == RESP);
    assign rspData    = rsp_data_q;
    assign rspError   = rsp_err_q;
    assign allocCount = alloc_q;

endmodule

// File: tb/tb_heap_array_unit.sv
// Directed bench for heap_array_unit at default parameters (W=12, NArea=10, NArrays=16).
module tb_heap_array_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqOp;
    logic [3:0]  reqArray;
    logic [3:0]  reqIndex;
    logic [11:0] reqData;
    logic        rspValid;
    logic        rspReady;
    logic [11:0] rspData;
    logic        rspError;
    logic [4:0]  allocCount;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  arr;
        logic [3:0]  idx;
        logic [11:0] d;
        logic [11:0] ed;
        logic        ee;
    } vec_t;

    heap_array_unit dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqArray(reqArray), .reqIndex(reqIndex), .reqData(reqData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspError(rspError), .allocCount(allocCount)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        reset = 1'b0; reqValid = 1'b0; rspReady = 1'b1;
        reqOp = '0; reqArray = '0; reqIndex = '0; reqData = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    // One full transaction from IDLE; a missing response counts as a failed check.
    task automatic do_req(input logic [2:0] op, input logic [3:0] arr, input logic [3:0] idx,
                          input logic [11:0] d, output logic [11:0] rd, output logic re);
        reqValid = 1'b1; reqOp = op; reqArray = arr; reqIndex = idx; reqData = d; rspReady = 1'b1;
        @(posedge clock); #1;
        reqValid = 1'b0;
        for (int i = 0; i < 10 && !rspValid; i++) begin
            @(posedge clock); #1;
        end
        if (!rspValid) begin
            n_total++;
            $display("FAIL timeout op=%0d arr=%0d: no rspValid within 10 cycles", op, arr);
        end
        rd = rspData;
        re = rspError;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (reqReady !== 1'b1) $display("FAIL reset_reqReady got %0b want 1", reqReady); else n_pass++;
        n_total++; if (rspValid !== 1'b0) $display("FAIL reset_rspValid got %0b want 0", rspValid); else n_pass++;
        n_total++; if (rspError !== 1'b0) $display("FAIL reset_rspError got %0b want 0", rspError); else n_pass++;
        n_total++; if (rspData !== 12'd0) $display("FAIL reset_rspData got %0d want 0", rspData); else n_pass++;
        n_total++; if (allocCount !== 5'd0) $display("FAIL reset_allocCount got %0d want 0", allocCount); else n_pass++;
    endtask

    task automatic test_basic();
        vec_t v [6];
        logic [11:0] rd;
        logic re;
        v = '{'{3'd0, 4'd0, 4'd0, 12'd0, 12'd0, 1'b0},
              '{3'd2, 4'd0, 4'd0, 12'd1, 12'd1, 1'b0},
              '{3'd2, 4'd0, 4'd0, 12'd2, 12'd2, 1'b0},
              '{3'd3, 4'd0, 4'd0, 12'd0, 12'd2, 1'b0},
              '{3'd3, 4'd0, 4'd0, 12'd0, 12'd1, 1'b0},
              '{3'd6, 4'd0, 4'd0, 12'd0, 12'd0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            do_req(v[i].op, v[i].arr, v[i].idx, v[i].d, rd, re);
            n_total++;
            if (rd !== v[i].ed || re !== v[i].ee)
                $display("FAIL basic[%0d] got data=%0d err=%0b want data=%0d err=%0b", i, rd, re, v[i].ed, v[i].ee);
            else n_pass++;
        end
        n_total++; if (allocCount !== 5'd1) $display("FAIL basic_allocCount got %0d want 1", allocCount); else n_pass++;
    endtask

    task automatic test_pop_empty();
        logic [11:0] rd;
        logic re;
        do_req(3'd3, 4'd0, 4'd0, 12'd0, rd, re);
        n_total++; if (rd !== 12'd0 || re !== 1'b1) $display("FAIL pop_empty got data=%0d err=%0b want data=0 err=1", rd, re); else n_pass++;
        do_req(3'd6, 4'd0, 4'd0, 12'd0, rd, re);
        n_total++; if (rd !== 12'd0 || re !== 1'b0) $display("FAIL pop_empty_size got data=%0d err=%0b want data=0 err=0", rd, re); else n_pass++;
    endtask

    task automatic test_lifo();
        vec_t v [9];
        logic [11:0] rd;
        logic re;
        apply_reset();
        v = '{'{3'd0, 4'd0, 4'd0, 12'd0, 12'd0, 1'b0},
              '{3'd0, 4'd0, 4'd0, 12'd0, 12'd1, 1'b0},
              '{3'd0, 4'd0, 4'd0, 12'd0, 12'd2, 1'b0},
              '{3'd1, 4'd1, 4'd0, 12'd0, 12'd0, 1'b0},
              '{3'd1, 4'd0, 4'd0, 12'd0, 12'd0, 1'b0},
              '{3'd0, 4'd0, 4'd0, 12'd0, 12'd0, 1'b0},
              '{3'd0, 4'd0, 4'd0, 12'd0, 12'd1, 1'b0},
              '{3'd0, 4'd0, 4'd0, 12'd0, 12'd3, 1'b0},
              '{3'd1, 4'd7, 4'd0, 12'd0, 12'd0, 1'b1}};
        for (int i = 0; i < 9; i++) begin
            do_req(v[i].op, v[i].arr, v[i].idx, v[i].d, rd, re);
            n_total++;
            if (rd !== v[i].ed || re !== v[i].ee)
                $display("FAIL lifo[%0d] got data=%0d err=%0b want data=%0d err=%0b", i, rd, re, v[i].ed, v[i].ee);
            else n_pass++;
        end
        n_total++; if (allocCount !== 5'd4) $display("FAIL lifo_allocCount got %0d want 4", allocCount); else n_pass++;
    endtask

    task automatic test_capacity();
        vec_t v [10];
        logic [11:0] rd;
        logic re;
        do_req(3'd0, 4'd0, 4'd0, 12'd0, rd, re);
        n_total++; if (rd !== 12'd4 || re !== 1'b0) $display("FAIL cap_alloc got data=%0d err=%0b want data=4 err=0", rd, re); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            do_req(3'd2, 4'd4, 4'd0, 12'(100 + i), rd, re);
            n_total++;
            if (rd !== 12'(i + 1) || re !== 1'b0)
                $display("FAIL cap_push[%0d] got data=%0d err=%0b want data=%0d err=0", i, rd, re, i + 1);
            else n_pass++;
        end
        v = '{'{3'd2, 4'd4, 4'd0, 12'd55,  12'd0,   1'b1},
              '{3'd6, 4'd4, 4'd0, 12'd0,   12'd10,  1'b0},
              '{3'd4, 4'd4, 4'd9, 12'd0,   12'd109, 1'b0},
              '{3'd0, 4'd0, 4'd0, 12'd0,   12'd5,   1'b0},
              '{3'd5, 4'd5, 4'd3, 12'h5A5, 12'd0,   1'b0},
              '{3'd6, 4'd5, 4'd0, 12'd0,   12'd4,   1'b0},
              '{3'd4, 4'd5, 4'd3, 12'd0,   12'h5A5, 1'b0},
              '{3'd4, 4'd5, 4'd5, 12'd0,   12'd0,   1'b1},
              '{3'd5, 4'd5, 4'd10, 12'd9,  12'd0,   1'b1},
              '{3'd7, 4'd5, 4'd0, 12'd0,   12'd0,   1'b1}};
        for (int i = 0; i < 10; i++) begin
            do_req(v[i].op, v[i].arr, v[i].idx, v[i].d, rd, re);
            n_total++;
            if (rd !== v[i].ed || re !== v[i].ee)
                $display("FAIL cap[%0d] got data=%0d err=%0b want data=%0d err=%0b", i, rd, re, v[i].ed, v[i].ee);
            else n_pass++;
        end
        do_req(3'd6, 4'd5, 4'd0, 12'd0, rd, re);
        n_total++; if (rd !== 12'd4 || re !== 1'b0) $display("FAIL cap_size_after_err got data=%0d err=%0b want data=4 err=0", rd, re); else n_pass++;
        do_req(3'd2, 4'd9, 4'd0, 12'd1, rd, re);
        n_total++; if (rd !== 12'd0 || re !== 1'b1) $display("FAIL cap_push_unalloc got data=%0d err=%0b want data=0 err=1", rd, re); else n_pass++;
        n_total++; if (allocCount !== 5'd6) $display("FAIL cap_allocCount got %0d want 6", allocCount); else n_pass++;
    endtask

    task automatic test_hold();
        logic [11:0] rd;
        logic re;
        reqValid = 1'b1; reqOp = 3'd3; reqArray = 4'd4; reqIndex = '0; reqData = '0; rspReady = 1'b0;
        @(posedge clock); #1;
        n_total++; if (rspValid !== 1'b0 || reqReady !== 1'b0) $display("FAIL hold_exec got rspValid=%0b reqReady=%0b want 0 0", rspValid, reqReady); else n_pass++;
        reqOp = 3'd0;
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (rspValid !== 1'b1) $display("FAIL hold_valid[%0d] got %0b want 1", i, rspValid); else n_pass++;
            n_total++; if (rspData !== 12'd109 || rspError !== 1'b0) $display("FAIL hold_data[%0d] got %0d err=%0b want 109 err=0", i, rspData, rspError); else n_pass++;
            n_total++; if (reqReady !== 1'b0) $display("FAIL hold_ready[%0d] got %0b want 0", i, reqReady); else n_pass++;
            @(posedge clock); #1;
        end
        reqValid = 1'b0; rspReady = 1'b1;
        @(posedge clock); #1;
        n_total++; if (rspValid !== 1'b0 || reqReady !== 1'b1) $display("FAIL hold_release got rspValid=%0b reqReady=%0b want 0 1", rspValid, reqReady); else n_pass++;
        do_req(3'd6, 4'd4, 4'd0, 12'd0, rd, re);
        n_total++; if (rd !== 12'd9 || re !== 1'b0) $display("FAIL hold_size got data=%0d err=%0b want data=9 err=0", rd, re); else n_pass++;
        n_total++; if (allocCount !== 5'd6) $display("FAIL hold_allocCount got %0d want 6", allocCount); else n_pass++;
    endtask

    task automatic test_reset_in_resp();
        logic [11:0] rd;
        logic re;
        reqValid = 1'b1; reqOp = 3'd6; reqArray = 4'd4; rspReady = 1'b0;
        @(posedge clock); #1;
        reqValid = 1'b0;
        @(posedge clock); #1;
        n_total++; if (rspValid !== 1'b1 || rspData !== 12'd9) $display("FAIL rst_pre got rspValid=%0b data=%0d want 1 9", rspValid, rspData); else n_pass++;
        reset = 1'b0;
        @(posedge clock); #1;
        n_total++; if (rspValid !== 1'b0) $display("FAIL rst_rspValid got %0b want 0", rspValid); else n_pass++;
        n_total++; if (allocCount !== 5'd0) $display("FAIL rst_allocCount got %0d want 0", allocCount); else n_pass++;
        n_total++; if (reqReady !== 1'b1) $display("FAIL rst_reqReady got %0b want 1", reqReady); else n_pass++;
        reset = 1'b1; rspReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_req(3'd0, 4'd0, 4'd0, 12'd0, rd, re);
            n_total++;
            if (rd !== 12'(i) || re !== 1'b0) $display("FAIL rst_alloc[%0d] got data=%0d err=%0b want data=%0d err=0", i, rd, re, i);
            else n_pass++;
        end
        do_req(3'd5, 4'd4, 4'd8, 12'h077, rd, re);
        n_total++; if (rd !== 12'd0 || re !== 1'b0) $display("FAIL rst_write got data=%0d err=%0b want data=0 err=0", rd, re); else n_pass++;
        do_req(3'd4, 4'd4, 4'd7, 12'd0, rd, re);
        n_total++; if (rd !== 12'd107 || re !== 1'b0) $display("FAIL rst_heap_kept got data=%0d err=%0b want data=107 err=0", rd, re); else n_pass++;
        do_req(3'd6, 4'd4, 4'd0, 12'd0, rd, re);
        n_total++; if (rd !== 12'd9 || re !== 1'b0) $display("FAIL rst_size got data=%0d err=%0b want data=9 err=0", rd, re); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pop_empty();
        test_lifo();
        test_capacity();
        test_hold();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
